// File: rtl/dma_engine_if.sv
// Command, channel status and RAM/accelerator bus bundle for dma_engine.
// "master" is the engine side. "slave" is the SoC side: the command latch plus both buses.
interface dma_engine_if #(
  parameter int NUM_CH = 4,
  parameter int LEN_W  = 16
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  // Handshakes: every valid/ready pair transfers on a rising edge where both are high.
  // The requester holds all request fields stable from valid rising until that edge.
  // Read data is sampled in the ready cycle.
  logic              cmd_valid;
  logic              cmd_ready;
  logic [CH_W-1:0]   cmd_ch;
  logic              cmd_dir;
  logic [31:0]       cmd_src;
  logic [31:0]       cmd_dst;
  logic [LEN_W-1:0]  cmd_len;
  logic [NUM_CH-1:0] abort;

  logic              ram_valid;
  logic              ram_write;
  logic [31:0]       ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
  logic              ram_ready;

  logic              acc_valid;
  logic              acc_write;
  logic [31:0]       acc_addr;
  logic [31:0]       acc_wdata;
  logic [3:0]        acc_wstrb;
  logic [31:0]       acc_rdata;
  logic              acc_ready;

  logic [NUM_CH-1:0] busy;
  logic [NUM_CH-1:0] done;
  logic [NUM_CH-1:0] aborted;
  logic [1:0]        dbg_state;

  modport master (
    input  cmd_valid, cmd_ch, cmd_dir, cmd_src, cmd_dst, cmd_len, abort,
    input  ram_rdata, ram_ready, acc_rdata, acc_ready,
    output cmd_ready,
    output ram_valid, ram_write, ram_addr, ram_wdata,
    output acc_valid, acc_write, acc_addr, acc_wdata, acc_wstrb,
    output busy, done, aborted, dbg_state
  );

  modport slave (
    output cmd_valid, cmd_ch, cmd_dir, cmd_src, cmd_dst, cmd_len, abort,
    output ram_rdata, ram_ready, acc_rdata, acc_ready,
    input  cmd_ready,
    input  ram_valid, ram_write, ram_addr, ram_wdata,
    input  acc_valid, acc_write, acc_addr, acc_wdata, acc_wstrb,
    input  busy, done, aborted, dbg_state
  );
endinterface

// File: rtl/dma_engine.sv
// Multi-channel word DMA between SoC RAM and the accelerator MMIO window.
// One shared engine moves up to BURST words per round-robin grant.
module dma_engine #(
  parameter int NUM_CH = 4,
  parameter int LEN_W  = 16,
  parameter int BURST  = 4
) (
  input logic         clk,
  input logic         rst,
  dma_engine_if.master bus
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BC_W = $clog2(BURST + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Per-channel context
  logic [NUM_CH-1:0] busy_q;
  logic [NUM_CH-1:0] done_q;
  logic [NUM_CH-1:0] aborted_q;
  logic [NUM_CH-1:0] abort_pend;
  logic [NUM_CH-1:0] ch_dir;
  logic [31:0]       ch_src [NUM_CH];
  logic [31:0]       ch_dst [NUM_CH];
  logic [LEN_W-1:0]  ch_rem [NUM_CH];

  // Shared engine context
  logic [CH_W-1:0]   cur_ch;
  logic [CH_W-1:0]   last_ch;
  logic [CH_W-1:0]   grant_ch;
  logic              grant_found;
  logic [BC_W-1:0]   burst_cnt;
  logic [31:0]       word_buf;

  logic              cur_dir;
  logic [31:0]       cur_src;
  logic [31:0]       cur_dst;
  logic [LEN_W-1:0]  cur_rem;
  logic              src_ready;
  logic              dst_ready;
  logic [31:0]       src_rdata;
  logic              rd_hs;
  logic              wr_hs;
  logic              last_word;
  logic              burst_end;
  logic              abort_hit;
  logic [NUM_CH-1:0] eligible;

  function automatic logic [CH_W-1:0] rr_idx(input logic [CH_W-1:0] base, input int step);
    int sum;
    sum = (int'(base) + step) % NUM_CH;
    return sum[CH_W-1:0];
  endfunction

  assign cur_dir   = ch_dir[cur_ch];
  assign cur_src   = ch_src[cur_ch];
  assign cur_dst   = ch_dst[cur_ch];
  assign cur_rem   = ch_rem[cur_ch];

  // dir 0 reads RAM and writes the accelerator; dir 1 is the reverse
  assign src_ready = cur_dir ? bus.acc_ready : bus.ram_ready;
  assign dst_ready = cur_dir ? bus.ram_ready : bus.acc_ready;
  assign src_rdata = cur_dir ? bus.acc_rdata : bus.ram_rdata;

  assign rd_hs     = (state == S_RD) && src_ready;
  assign wr_hs     = (state == S_WR) && dst_ready;
  assign last_word = (cur_rem == LEN_W'(1));
  assign burst_end = ((burst_cnt + 1'b1) == BC_W'(BURST));
  assign abort_hit = abort_pend[cur_ch] | bus.abort[cur_ch];

  // A channel being aborted this cycle is never handed a new grant
  assign eligible  = busy_q & ~bus.abort;

  always_comb begin
    grant_found = 1'b0;
    grant_ch    = last_ch;
    for (int k = 1; k <= NUM_CH; k++) begin
      if (!grant_found && eligible[rr_idx(last_ch, k)]) begin
        grant_found = 1'b1;
        grant_ch    = rr_idx(last_ch, k);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (grant_found) begin
          state_nxt = S_RD;
        end
      end
      S_RD: begin
        if (src_ready) begin
          state_nxt = S_WR;
        end
      end
      S_WR: begin
        if (dst_ready) begin
          if (last_word || burst_end || abort_hit) begin
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_RD;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Port requests decode straight from the state register, so reset drops them at once
  always_comb begin
    bus.ram_valid = 1'b0;
    bus.ram_write = 1'b0;
    bus.ram_addr  = 32'd0;
    bus.ram_wdata = 32'd0;
    bus.acc_valid = 1'b0;
    bus.acc_write = 1'b0;
    bus.acc_addr  = 32'd0;
    bus.acc_wdata = 32'd0;
    bus.acc_wstrb = 4'd0;
    if (state == S_RD) begin
      if (cur_dir) begin
        bus.acc_valid = 1'b1;
        bus.acc_addr  = cur_src;
      end else begin
        bus.ram_valid = 1'b1;
        bus.ram_addr  = cur_src;
      end
    end else if (state == S_WR) begin
      if (cur_dir) begin
        bus.ram_valid = 1'b1;
        bus.ram_write = 1'b1;
        bus.ram_addr  = cur_dst;
        bus.ram_wdata = word_buf;
      end else begin
        bus.acc_valid = 1'b1;
        bus.acc_write = 1'b1;
        bus.acc_addr  = cur_dst;
        bus.acc_wdata = word_buf;
        bus.acc_wstrb = 4'hF;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_ch    <= '0;
      last_ch   <= '0;
      burst_cnt <= '0;
      word_buf  <= 32'd0;
    end else begin
      if (state == S_IDLE && grant_found) begin
        cur_ch    <= grant_ch;
        last_ch   <= grant_ch;
        burst_cnt <= '0;
      end
      if (rd_hs) begin
        word_buf <= src_rdata;
      end
      if (wr_hs) begin
        burst_cnt <= burst_cnt + 1'b1;
      end
    end
  end

  // Channel bookkeeping: accept, per-word advance, completion and abort
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q     <= '0;
      done_q     <= '0;
      aborted_q  <= '0;
      abort_pend <= '0;
      ch_dir     <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        ch_src[i] <= 32'd0;
        ch_dst[i] <= 32'd0;
        ch_rem[i] <= '0;
      end
    end else begin
      done_q    <= '0;
      aborted_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (busy_q[i]) begin
          if (state != S_IDLE && cur_ch == CH_W'(i)) begin
            if (bus.abort[i]) begin
              abort_pend[i] <= 1'b1;
            end
            if (wr_hs) begin
              ch_src[i] <= ch_src[i] + 32'd4;
              ch_dst[i] <= ch_dst[i] + 32'd4;
              ch_rem[i] <= ch_rem[i] - 1'b1;
              // The final word wins over a coincident abort
              if (last_word) begin
                busy_q[i]     <= 1'b0;
                done_q[i]     <= 1'b1;
                abort_pend[i] <= 1'b0;
              end else if (abort_hit) begin
                busy_q[i]     <= 1'b0;
                aborted_q[i]  <= 1'b1;
                abort_pend[i] <= 1'b0;
              end
            end
          end else if (bus.abort[i]) begin
            busy_q[i]     <= 1'b0;
            aborted_q[i]  <= 1'b1;
            abort_pend[i] <= 1'b0;
          end
        end else if (bus.cmd_valid && bus.cmd_ch == CH_W'(i)) begin
          ch_dir[i] <= bus.cmd_dir;
          ch_src[i] <= bus.cmd_src & ~32'h3;
          ch_dst[i] <= bus.cmd_dst & ~32'h3;
          ch_rem[i] <= bus.cmd_len;
          if (bus.cmd_len == '0) begin
            done_q[i] <= 1'b1;
          end else begin
            busy_q[i] <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.cmd_ready = !busy_q[bus.cmd_ch];
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.aborted   = aborted_q;
  assign bus.dbg_state = state;

endmodule

// File: doc/dma_engine.md
# dma_engine

Multi-channel, bidirectional word DMA engine that moves 32-bit words between SoC RAM and the matrix accelerator MMIO window without CPU load/store traffic. It sits in `riscv_soc` between the custom-PCPI command latch and the RAM/accelerator buses, replacing the single-channel RAM→accelerator DMA. It is generalised in channel count, transfer direction and burst granularity, and adds per-channel status, round-robin arbitration, abort and completion pulses.

## Interface
- `NUM_CH`, 4: number of independent channels (≥1); `CH_W = max(1,$clog2(NUM_CH))`.
- `LEN_W`, 16: width of the transfer length in words.
- `BURST`, 4: maximum words moved per arbitration grant (≥1).
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `cmd_valid`  in  1  program a channel.
- `cmd_ready`  out  1  `= !busy[cmd_ch]`.
- `cmd_ch`  in  CH_W  target channel.
- `cmd_dir`  in  1  0: RAM→accel; 1: accel→RAM.
- `cmd_src`, `cmd_dst`  in  32  byte addresses. Bits [1:0] are ignored.
- `cmd_len`  in  LEN_W  length in words.
- `abort`  in  NUM_CH  per-channel abort request, level-sampled.
- `ram_valid`, `ram_write`  out  1  RAM port request.
- `ram_addr`, `ram_wdata`  out  32.
- `ram_rdata`  in  32.
- `ram_ready`  in  1.
- `acc_valid`, `acc_write`  out  1  accelerator port request.
- `acc_addr`, `acc_wdata`  out  32.
- `acc_wstrb`  out  4.
- `acc_rdata`  in  32.
- `acc_ready`  in  1.
- `busy`  out  NUM_CH  channel active.
- `done`  out  NUM_CH  one-cycle completion pulse.
- `aborted`  out  NUM_CH  one-cycle abort-acknowledge pulse.

## Operation
- **Port protocol:** both ports use valid/ready. A request is held stable until `ready` is sampled high. On a read (`write=0`), `rdata` is valid in the `ready` cycle. `acc_wstrb` is 4'b1111 on writes and 0 otherwise. Addresses are driven with [1:0]=0.
- **Command accept:** on `cmd_valid && cmd_ready` the channel stores dir, src, dst and len, and `busy[ch]` sets.
  - `cmd_len==0`: `busy` stays 0 and `done[ch]` pulses the next cycle.
- **Engine FSM:** IDLE → RD → WR → (RD | IDLE).
  - **IDLE:** if any `busy`, select a channel round-robin, searching upward from the channel after the last granted one and wrapping. Clear the burst counter and go to RD. Otherwise stay.
  - **RD:** drive the source port as a read at the current src. On `ready`, latch rdata into the word buffer and go to WR.
  - **WR:** drive the destination port as a write of the buffer to the current dst. On `ready`:
    - src += 4 and dst += 4, both modulo 2^32;
    - remaining −= 1 and burst count += 1;
    - if remaining==0: pulse `done`, clear `busy`, go to IDLE;
    - else if burst count==BURST, or `abort` is pending for this channel: go to IDLE;
    - else go to RD.
- **Source/destination selection:** dir 0 reads RAM and writes accel. dir 1 reads accel and writes RAM. Only one port is active in any cycle.
- **Abort:**
  - Idle (non-granted) busy channel: `busy` clears and `aborted` pulses the cycle after `abort` is sampled.
  - Granted channel: the in-flight word completes (RD+WR), then `busy` clears and `aborted` pulses, with no `done`.
  - `abort` on a non-busy channel is ignored.
  - An abort coinciding with the final word's WR handshake yields `done`, not `aborted`.
- A channel's registers are never rewritten while it is busy; `cmd_ready` is low for it.

## Timing
- **Reset values:** all `*_valid`, `*_write`, addr, wdata and wstrb = 0; `busy`, `done`, `aborted` = 0; FSM = IDLE; RR pointer = 0. `cmd_ready` = 1.
- **Start latency:** command accepted at edge T. IDLE grants at T+1. RD `valid` is high from cycle T+1→T+2 edge onward, i.e. the first request is visible in the cycle after the accept edge plus one.
- **Throughput:** zero-wait ports give 2 cycles/word plus 1 IDLE cycle per grant. A full-BURST grant takes 2·BURST+1 cycles.
- **Completion:** `done`/`aborted` are registered pulses asserted in the cycle after the final WR handshake. `busy` falls on the same edge.
- **Command to a completing channel:** `cmd_ready` stays low in the handshake cycle. The channel becomes acceptable one cycle later.
- **Mid-operation reset:** all channel state is discarded and no pulses are emitted. Port valids drop asynchronously.

## Test plan
- **Single channel:** ch0, dir0, src 0x100, dst 0x40, len 3, zero-wait ports.
  - RAM reads at 0x100/0x104/0x108; accel writes at 0x40/0x44/0x48 with matching data.
  - `done[0]` pulses once; total 7 cycles from first request.
- **Two channels, BURST=4:** ch1 len 6 and ch2 len 2 accepted in consecutive cycles.
  - Grant order: ch1 ×4 words, ch2 ×2, ch1 ×2. `done[2]` precedes `done[1]`.
- **Accel→RAM with backpressure:** dir1, len 2, `acc_ready` delayed 3 cycles per read.
  - `acc_valid`, `acc_addr` and `acc_write=0` are held stable through the stall.
  - RAM gets the exact rdata values.
- **Length zero and busy reprogram:**
  - `cmd_len=0` on ch3 → `done[3]` pulses next cycle, with no port activity.
  - A command to busy ch0 sees `cmd_ready=0` until after `done[0]`.
- **Abort:**
  - Abort the granted ch0 during WR of word 2 of 5 → exactly 2 words written, `aborted[0]` pulses, no `done[0]`.
  - Abort a waiting channel → `aborted` pulses the next cycle.
- **Address wrap and reset:**
  - src 0xFFFFFFFC, len 2 → second read at 0x00000000.
  - Assert `rst` during RD → all outputs 0 immediately, and a fresh command then runs normally.
